// File: rtl/alu_mul_pkg.sv
// ============================================================================
// alu_mul_pkg : ALU operation codes and multiplier step configuration
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_mul_pkg;

    localparam logic [5:0] ALU_ADD    = 6'd0;
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;

`ifdef MUL_RADIX4_EN
    localparam int unsigned STEP_BITS = 2;
`else
    localparam int unsigned STEP_BITS = 1;
`endif
    localparam int unsigned N_STEPS = 32 / STEP_BITS;

    function automatic logic is_mul_op(input logic [5:0] code);
        return (code == ALU_MUL) || (code == ALU_MULH) ||
               (code == ALU_MULHSU) || (code == ALU_MULHU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_if.sv
// ============================================================================
// alu_mul_if : request/result bundle between requester and alu_mul
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface alu_mul_if;
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        valid;
    logic [31:0] alu_result;

    modport master (output alucode, op1, op2, input busy, valid, alu_result);
    modport slave  (input alucode, op1, op2, output busy, valid, alu_result);
endinterface

`default_nettype wire

// File: rtl/alu_mul_step.sv
// ============================================================================
// alu_mul_step : one shift-add step, accumulator plus selected partial product
// Revision     : 1.0   (radix selected by MUL_RADIX4_EN)
// ============================================================================
`default_nettype none

module alu_mul_step
    import alu_mul_pkg::*;
(
    input  wire logic [63:0]          acc,
    input  wire logic [63:0]          mcand,
    input  wire logic [STEP_BITS-1:0] mbits,
    output logic      [63:0]          acc_next
);

    logic [63:0] pp;

`ifdef MUL_RADIX4_EN
    always_comb begin
        pp = '0;
        case (mbits)
            2'd1:    pp = mcand;
            2'd2:    pp = mcand << 1;
            2'd3:    pp = mcand + (mcand << 1);
            default: pp = '0;
        endcase
    end
`else
    assign pp = mbits[0] ? mcand : '0;
`endif

    assign acc_next = acc + pp;

endmodule

`default_nettype wire

// File: rtl/alu_mul.sv
// ============================================================================
// alu_mul : iterative 32x32 multiplier for MUL/MULH/MULHSU/MULHU
// Revision: 1.0   (define MUL_RADIX4_EN for 2 multiplier bits per step)
// ============================================================================
`default_nettype none

module alu_mul
    import alu_mul_pkg::*;
(
    input wire logic  clk,
    input wire logic  rst,
    alu_mul_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [5:0] LAST_CNT = 6'(N_STEPS);

    logic [1:0]  state_q,   state_d;
    logic [63:0] mcand_q,   mcand_d;
    logic [31:0] mplier_q,  mplier_d;
    logic [63:0] acc_q,     acc_d;
    logic [5:0]  cnt_q,     cnt_d;
    logic        lo_q,      lo_d;
    logic        outsign_q, outsign_d;

    logic        start;
    logic        neg1, neg2;
    logic [31:0] mag1, mag2;
    logic [63:0] acc_step;

    assign start = is_mul_op(bus.alucode);
    // op1 is signed for every op except MULHU; op2 only for MUL/MULH
    assign neg1  = (bus.alucode != ALU_MULHU) & bus.op1[31];
    assign neg2  = ((bus.alucode == ALU_MUL) | (bus.alucode == ALU_MULH)) & bus.op2[31];
    assign mag1  = neg1 ? (~bus.op1 + 32'd1) : bus.op1;
    assign mag2  = neg2 ? (~bus.op2 + 32'd1) : bus.op2;

    alu_mul_step u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .mbits    (mplier_q[STEP_BITS-1:0]),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            lo_q      <= 1'b0;
            outsign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            outsign_q <= outsign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EXEC;
            S_EXEC:  if (cnt_q == LAST_CNT) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        outsign_d = outsign_q;
        if (state_q == S_IDLE && start) begin
            mcand_d   = {32'd0, mag1};
            mplier_d  = mag2;
            acc_d     = '0;
            cnt_d     = '0;
            lo_d      = (bus.alucode == ALU_MUL);
            outsign_d = neg1 ^ neg2;
        end else if (state_q == S_EXEC) begin
            if (cnt_q != LAST_CNT) begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                cnt_d    = cnt_q + 6'd1;
            end else if (outsign_q) begin
                // Sign fix-up costs one extra cycle after the final step
                acc_d = ~acc_q + 64'd1;
            end
        end
    end

    always_comb begin
        bus.busy       = (state_q == S_EXEC) || (state_q == S_FIN);
        bus.valid      = (state_q == S_FIN);
        bus.alu_result = '0;
        if (state_q == S_FIN) begin
            bus.alu_result = lo_q ? acc_q[31:0] : acc_q[63:32];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul.sv
// ============================================================================
// tb_alu_mul : directed self-checking bench for alu_mul
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul;
    import alu_mul_pkg::*;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    alu_mul_if bus ();

    alu_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, check latency, result and one-cycle valid strobe
    task automatic run_op(input string tag, input logic [5:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit disturb);
        int early;
        early = 0;
        @(negedge clk);
        bus.alucode = code;
        bus.op1     = a;
        bus.op2     = b;
        @(posedge clk);
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) early++;
            if (i == 5) chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            if (disturb && i == 3) begin
                bus.alucode = ALU_ADD;
                bus.op1     = '0;
                bus.op2     = '0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " early valid"}, 32'(early), 32'd0);
        chk({tag, " valid"}, {31'd0, bus.valid}, 32'd1);
        chk({tag, " result"}, bus.alu_result, exp);
        bus.alucode = ALU_ADD;
        @(posedge clk);
        #1;
        chk({tag, " valid one cycle"}, {31'd0, bus.valid}, 32'd0);
        chk({tag, " result idle"}, bus.alu_result, 32'd0);
    endtask

    initial begin
        int bad;
        rst         = 1'b0;
        bus.alucode = ALU_ADD;
        bus.op1     = '0;
        bus.op2     = '0;
        #12;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset valid", {31'd0, bus.valid}, 32'd0);
        chk("reset result", bus.alu_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul 7x-3",      ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulh min*min",  ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("mulhu max*max", ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulhsu -1*max", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mul 0*x",       ALU_MUL,    32'd0,        32'h12345678, 32'd0,        1'b0);
        run_op("mul disturbed", ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);

        // Non-multiply code must never start the engine
        @(negedge clk);
        bus.alucode = ALU_ADD;
        bus.op1     = 32'd5;
        bus.op2     = 32'd9;
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.valid) bad++;
        end
        chk("idle no start", 32'(bad), 32'd0);

        // Reset in the middle of S_EXEC
        @(negedge clk);
        bus.alucode = ALU_MUL;
        bus.op1     = 32'h1234;
        bus.op2     = 32'h10;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async busy", {31'd0, bus.busy}, 32'd0);
        chk("async valid", {31'd0, bus.valid}, 32'd0);
        chk("async result", bus.alu_result, 32'd0);
        bus.alucode = ALU_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.busy) bad++;
        end
        chk("aborted no valid", 32'(bad), 32'd0);
        run_op("mul 3x5", ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_mul.md
ALU_MUL -- requirements
Module: alu_mul

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port alucode, input, 6, ALU operation code; multiply ops are ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
REQ-004 SHALL have ports op1 and op2, input, 32 each: multiplicand and multiplier.
REQ-005 SHALL have port busy, output, 1, high in S_EXEC and S_FIN.
REQ-006 SHALL have port valid, output, 1, one-cycle result strobe.
REQ-007 SHALL have port alu_result, output, 32, product slice; 0 whenever valid is low.

Function
REQ-008 SHALL use a state machine with states S_IDLE, S_EXEC and S_FIN.
REQ-009 start SHALL be true when alucode is one of the four multiply codes.
REQ-010 In S_IDLE with start true at an edge, the block SHALL latch the operands, the op type and the output sign, clear the accumulator and counter, and enter S_EXEC.
REQ-011 The block SHALL take op1 as signed for MUL/MULH/MULHSU and op2 as signed for MUL/MULH only.
REQ-012 The block SHALL latch the magnitude of each signed operand; outsign = (s1 & op1[31]) ^ (s2 & op2[31]).
REQ-013 S_EXEC SHALL do one unsigned shift-add step per cycle: if multiplier LSB = 1, add the 64-bit left-aligned multiplicand to the 64-bit accumulator; shift the multiplicand left 1 and the multiplier right 1.
REQ-014 S_EXEC SHALL run exactly 32 steps, then go to S_FIN; the product is negated (64-bit two's complement) when outsign = 1.
REQ-015 S_FIN SHALL assert valid for one cycle and drive alu_result = product[31:0] for MUL, else product[63:32]; next state S_IDLE.
REQ-016 Latency SHALL be: start sampled at edge N -> valid high in the cycle after edge N+33.
REQ-017 The result type and sign SHALL come from latched values; alucode/op changes during S_EXEC/S_FIN SHALL be ignored.
REQ-018 If start is still true in S_IDLE after S_FIN, a new operation SHALL launch; the requester drops alucode on valid.
REQ-019 MULH of 0x80000000 x 0x80000000 (magnitude 2^31) SHALL be exact; no overflow flag exists.

Reset
REQ-020 rst low SHALL force S_IDLE, clear all data registers and the counter, and drive busy = 0, valid = 0, alu_result = 0 asynchronously.
REQ-021 Reset during S_EXEC SHALL abort the operation with no valid pulse; the next start after release behaves as from power-up.

Configuration
REQ-022 Macro MUL_RADIX4_EN: when defined, each S_EXEC step SHALL consume 2 multiplier bits (add 0/1/2/3x multiplicand, shift by 2), giving 16 steps and valid after edge N+17.
REQ-023 Without MUL_RADIX4_EN, the 32-step radix-2 behaviour SHALL apply; results SHALL be bit-identical in both builds.

Structure
REQ-024 The ALU_MUL* codes SHALL live in the shared define.vh header alongside the existing ALU codes; state localparams remain local.
REQ-025 One combinational sub-module, mul_step (accumulator + selected partial product, radix per macro), is natural; everything else SHALL be flat.

Verification
REQ-026 Bench SHALL check: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; valid exactly one cycle, after edge N+33 (N+17 radix-4).
REQ-027 Bench SHALL check: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-028 Bench SHALL check: MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0 x 0x12345678 -> 0.
REQ-029 Bench SHALL check: after start, change alucode to ADD and the ops to 0 during S_EXEC -> the original result is still produced.
REQ-030 Bench SHALL check: assert rst 10 cycles into S_EXEC -> busy/valid/alu_result = 0 immediately, no valid pulse; then MUL 3 x 5 -> 15.
REQ-031 Bench SHALL check: non-multiply alucode held in S_IDLE for 50 cycles -> busy and valid stay 0.
